// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter and single-beat sequencer for the I/O controller's internal bus.
// Owns the bus address/data latch and the one-cycle write strobe; locked owners may burst up to HOLD_MAX beats.
module io_bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int HOLD_MAX = 8,
  parameter int PRIO0    = 1
) (
  input  logic                 iBusClock,
  input  logic                 iBoardReset,
  input  logic [NREQ-1:0]      iReqValid,
  input  logic [NREQ-1:0]      iReqWrite,
  input  logic [NREQ-1:0]      iReqLock,
  input  logic [NREQ*15-1:0]   iReqAddr,
  input  logic [NREQ*16-1:0]   iReqData,
  output logic [NREQ-1:0]      oReqGrant,
  output logic [NREQ-1:0]      oReqDone,
  output logic [31:0]          oReqRData,
  output logic [14:0]          oBusAddress,
  output logic [15:0]          oBusData,
  output logic                 oBusWrite,
  input  logic [31:0]          iBusRData,
  output logic [2:0]           oBusOwner,
  output logic                 oBusy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t          state;
  logic [2:0]      rrPtr;
  logic [7:0]      beatCnt;

  logic [NREQ-1:0] rotValid;
  logic [2:0]      winner;
  logic            winFound;
  logic [NREQ-1:0] winOh;
  logic [14:0]     winAddr;
  logic [15:0]     winData;
  logic            winWrite;
  logic [14:0]     ownAddr;
  logic [15:0]     ownData;
  logic            ownWrite;
  logic            reArm;

  // Search starts one past the pointer, so the last owner is considered last.
  always_comb begin
    rotValid = NREQ'({iReqValid, iReqValid} >> (int'(rrPtr) + 1));
    winner   = 3'd0;
    winFound = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!winFound && rotValid[i]) begin
        winner   = 3'((int'(rrPtr) + 1 + i) % NREQ);
        winFound = 1'b1;
      end
    end
    if (PRIO0 != 0 && iReqValid[0]) winner = 3'd0;
    winOh = NREQ'(1) << winner;
  end

  always_comb begin
    winAddr  = '0;
    winData  = '0;
    winWrite = 1'b0;
    ownAddr  = '0;
    ownData  = '0;
    ownWrite = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (winOh[i]) begin
        winAddr  = iReqAddr[15*i +: 15];
        winData  = iReqData[16*i +: 16];
        winWrite = iReqWrite[i];
      end
      if (oReqGrant[i]) begin
        ownAddr  = iReqAddr[15*i +: 15];
        ownData  = iReqData[16*i +: 16];
        ownWrite = iReqWrite[i];
      end
    end
  end

  assign reArm = (|(oReqGrant & iReqValid & iReqLock)) && (beatCnt < 8'(HOLD_MAX));

  always_ff @(posedge iBusClock) begin
    if (!iBoardReset) begin
      state       <= IDLE;
      rrPtr       <= 3'(NREQ - 1);
      beatCnt     <= 8'd0;
      oReqGrant   <= '0;
      oReqDone    <= '0;
      oReqRData   <= '0;
      oBusAddress <= '0;
      oBusData    <= '0;
      oBusWrite   <= 1'b0;
      oBusOwner   <= 3'd0;
      oBusy       <= 1'b0;
    end else begin
      oReqDone <= '0;
      case (state)
        IDLE: begin
          if (|iReqValid) begin
            oBusAddress <= winAddr;
            oBusData    <= winData;
            oBusWrite   <= winWrite;
            oReqGrant   <= winOh;
            oBusOwner   <= winner;
            oBusy       <= 1'b1;
            beatCnt     <= 8'd1;
            state       <= ADDR;
          end
        end
        ADDR: begin
          oBusWrite <= 1'b0;
          state     <= DATA;
        end
        DATA: begin
          oReqRData <= iBusRData;
          oReqDone  <= oReqGrant;
          if (reArm) begin
            oBusAddress <= ownAddr;
            oBusData    <= ownData;
            oBusWrite   <= ownWrite;
            beatCnt     <= beatCnt + 8'd1;
            state       <= ADDR;
          end else begin
            // Released owner becomes the pointer, giving it lowest priority next round.
            rrPtr     <= oBusOwner;
            oReqGrant <= '0;
            oBusOwner <= 3'd0;
            oBusy     <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_grantOneHot: assert property (@(posedge iBusClock) disable iff (!iBoardReset)
    $onehot0(oReqGrant));
  a_ownerStable: assert property (@(posedge iBusClock) disable iff (!iBoardReset)
    (state == ADDR) |=> ($stable(oReqGrant) && $stable(oBusOwner)));
  a_strobeInAddr: assert property (@(posedge iBusClock) disable iff (!iBoardReset)
    oBusWrite |-> (state == ADDR));

endmodule
